// File: rtl/apb_regbank_slave.sv
// APB completer with a bank of 32-bit registers; register NUM_REGS-1 is a read-only status view.
// Optional wait-state counter is compiled in with `define REGBANK_WAIT_EN (WAIT_CYCLES stalls per access).
module apb_regbank_slave #(
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        HCLK,
  input  logic        HRST,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic [31:0] status_i,
  output logic [31:0] ctrl_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic        wr_q, err_q;
  logic [5:0]  idx_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0]  strb_q;
  logic [31:0] regs [NUM_REGS-1];

  logic [5:0]  idx;
  logic        setup, done, rdy, wr_en, err_in;
  logic [31:0] rd_mux;
  logic        unused_paddr;

  assign idx          = PADDR[7:2];
  assign unused_paddr = ^PADDR[31:8];
  assign setup        = (state == IDLE) && PSEL && !PENABLE;
  assign done         = (state == ACCESS) && PSEL && PENABLE && rdy;
  assign wr_en        = done && wr_q && !err_q;

  assign err_in = (int'(idx) >= NUM_REGS) || (PADDR[1:0] != 2'b00) ||
                  (PWRITE && (int'(idx) == NUM_REGS - 1));

`ifdef REGBANK_WAIT_EN
  logic [3:0] cnt_q;

  // Counter only advances while the master is actually in the access phase.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST)                                              cnt_q <= 4'd0;
    else if (setup)                                        cnt_q <= 4'(WAIT_CYCLES);
    else if ((state == ACCESS) && PSEL && PENABLE && (cnt_q != 4'd0)) cnt_q <= cnt_q - 4'd1;
  end

  assign rdy = (cnt_q == 4'd0);
`else
  localparam int unused_wait = WAIT_CYCLES;
  assign rdy = 1'b1;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment up front keeps this comb block from inferring a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (PSEL && !PENABLE) state_nxt = ACCESS;
      ACCESS:  if (!PSEL || done)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from flops only.
  always_comb begin
    PREADY  = (state == ACCESS) && rdy;
    PSLVERR = PREADY && err_q;
    PRDATA  = (PREADY && !wr_q && !err_q) ? rdata_q : 32'd0;
  end

  always_comb begin
    rd_mux = 32'd0;
    if (int'(idx) == NUM_REGS - 1) rd_mux = status_i;
    for (int r = 0; r < NUM_REGS - 1; r++)
      if (int'(idx) == r) rd_mux = regs[r];
  end

  // Setup-phase capture; read data is frozen here so status_i may move during the access.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= 6'd0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      rdata_q <= 32'd0;
    end else if (setup) begin
      wr_q    <= PWRITE;
      err_q   <= err_in;
      idx_q   <= idx;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
      rdata_q <= err_in ? 32'd0 : rd_mux;
    end
  end

  // NOTE: the register bank is reset because software relies on every register reading 0 after reset.
  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      for (int r = 0; r < NUM_REGS - 1; r++) regs[r] <= 32'd0;
    end else if (wr_en) begin
      for (int r = 0; r < NUM_REGS - 1; r++)
        for (int b = 0; b < 4; b++)
          if ((int'(idx_q) == r) && strb_q[b]) regs[r][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  assign ctrl_o = regs[0];

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Self-checking bench for apb_regbank_slave: directed vector table, multi-cycle corner sequences,
// and random transfers checked against an array-based register model.
module tb_apb_regbank_slave;

  localparam int NREG = 8;
`ifdef REGBANK_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRST = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0, status_i = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PRDATA, ctrl_o;
  logic        PREADY, PSLVERR;

  apb_regbank_slave #(.NUM_REGS(NREG), .WAIT_CYCLES(2)) dut (
    .HCLK(HCLK), .HRST(HRST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .status_i(status_i), .ctrl_o(ctrl_o)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain array of register values.
  logic [31:0] model [NREG];

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
  endtask

  task automatic model_xfer(input bit wr, input logic [31:0] addr, wdata, input logic [3:0] strb,
                            input logic [31:0] status, output logic [31:0] rd, output bit err);
    int i;
    i   = int'(addr[7:2]);
    err = (i >= NREG) || (addr[1:0] != 2'b00) || (wr && i == NREG - 1);
    rd  = 32'd0;
    if (!err && !wr) rd = (i == NREG - 1) ? status : model[i];
    if (!err && wr)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[i][8*b +: 8] = wdata[8*b +: 8];
  endtask

  // One complete transfer; returns the sampled response and the number of wait cycles seen.
  task automatic xfer(input bit wr, input logic [31:0] addr, wdata, input logic [3:0] strb,
                      input logic [31:0] status, output logic [31:0] rdata, output bit err,
                      output int waits);
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    status_i = status;
    @(negedge HCLK);
    PENABLE  = 1'b1;
    status_i = ~status;
    waits = 0;
    while (!PREADY && waits < 40) begin
      @(negedge HCLK);
      waits++;
    end
    check("pready_seen", {31'd0, PREADY}, 32'd1);
    rdata = PRDATA;
    err   = PSLVERR;
  endtask

  task automatic go_idle();
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    check("pready_one_cycle", {31'd0, PREADY}, 32'd0);
  endtask

  task automatic run_and_check(input string tag, input bit wr, input logic [31:0] addr, wdata,
                               input logic [3:0] strb, input logic [31:0] status);
    logic [31:0] rd, erd;
    bit          err, eerr;
    int          waits;
    model_xfer(wr, addr, wdata, strb, status, erd, eerr);
    xfer(wr, addr, wdata, strb, status, rd, err, waits);
    check({tag, "_prdata"}, rd, erd);
    check({tag, "_pslverr"}, {31'd0, err}, {31'd0, eerr});
    check({tag, "_waits"}, waits, W);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] status;
    logic [31:0] exp_rdata;
    bit          exp_err;
    logic [31:0] exp_ctrl;
  } vec_t;

  vec_t tbl [16];
  int   n_vec = 0;

  task automatic add(input bit wr, input logic [31:0] addr, wdata, input logic [3:0] strb,
                     input logic [31:0] status, exp_rdata, input bit exp_err,
                     input logic [31:0] exp_ctrl);
    tbl[n_vec] = '{wr, addr, wdata, strb, status, exp_rdata, exp_err, exp_ctrl};
    n_vec++;
  endtask

  initial begin
    logic [31:0] rd, d;
    bit          err, e;
    int          waits, idx;
    bit          wr;
    logic [31:0] addr;

    // Directed vectors: wr, addr, wdata, strb, status, exp_rdata, exp_err, exp_ctrl.
    add(1, 32'h08, 32'hA5A5_1234, 4'hF, 32'h0,         32'h0,         0, 32'h0);
    add(0, 32'h08, 32'h0,         4'h0, 32'h0,         32'hA5A5_1234, 0, 32'h0);
    add(1, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0,         32'h0,         0, 32'hFFFF_FFFF);
    add(1, 32'h00, 32'h0000_0000, 4'h5, 32'h0,         32'h0,         0, 32'hFF00_FF00);
    add(0, 32'h00, 32'h0,         4'h0, 32'h0,         32'hFF00_FF00, 0, 32'hFF00_FF00);
    add(0, 32'h1C, 32'h0,         4'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 32'hFF00_FF00);
    add(1, 32'h1C, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 32'h0,         1, 32'hFF00_FF00);
    add(0, 32'h1C, 32'h0,         4'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 32'hFF00_FF00);
    add(1, 32'h20, 32'h7777_7777, 4'hF, 32'h0,         32'h0,         1, 32'hFF00_FF00);
    add(0, 32'h20, 32'h0,         4'h0, 32'h0,         32'h0,         1, 32'hFF00_FF00);
    add(1, 32'h06, 32'h5555_5555, 4'hF, 32'h0,         32'h0,         1, 32'hFF00_FF00);
    add(0, 32'h06, 32'h0,         4'h0, 32'h0,         32'h0,         1, 32'hFF00_FF00);
    add(0, 32'h04, 32'h0,         4'h0, 32'h0,         32'h0,         0, 32'hFF00_FF00);
    add(1, 32'h08, 32'hFFFF_FFFF, 4'h0, 32'h0,         32'h0,         0, 32'hFF00_FF00);
    add(0, 32'h08, 32'h0,         4'h0, 32'h0,         32'hA5A5_1234, 0, 32'hFF00_FF00);
    add(1, 32'h00, 32'h0102_0304, 4'h8, 32'h0,         32'h0,         0, 32'h0100_FF00);

    model_reset();
    #12;
    check("reset_pready",  {31'd0, PREADY},  32'd0);
    check("reset_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("reset_prdata",  PRDATA, 32'd0);
    check("reset_ctrl",    ctrl_o, 32'd0);
    @(negedge HCLK);
    HRST = 1'b0;

    for (int v = 0; v < n_vec; v++) begin
      model_xfer(tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].strb, tbl[v].status, d, e);
      xfer(tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].strb, tbl[v].status, rd, err, waits);
      check($sformatf("vec%0d_prdata", v), rd, tbl[v].exp_rdata);
      check($sformatf("vec%0d_pslverr", v), {31'd0, err}, {31'd0, tbl[v].exp_err});
      check($sformatf("vec%0d_waits", v), waits, W);
      go_idle();
      check($sformatf("vec%0d_ctrl", v), ctrl_o, tbl[v].exp_ctrl);
    end

    // Abort: PSEL drops right after setup, before the write can complete.
    run_and_check("abort_pre", 1, 32'h04, 32'h1111_1111, 4'hF, 32'h0);
    go_idle();
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'h2222_2222; PSTRB = 4'hF;
    @(negedge HCLK);
    PSEL = 1'b0;
    @(negedge HCLK);
    check("abort_idle_pready", {31'd0, PREADY}, 32'd0);
    run_and_check("abort_readback", 0, 32'h04, 32'h0, 4'h0, 32'h0);
    go_idle();

    // Back-to-back: second setup lands in the cycle right after PREADY.
    run_and_check("b2b_w", 1, 32'h0C, 32'hCAFE_F00D, 4'hF, 32'h0);
    run_and_check("b2b_r", 0, 32'h0C, 32'h0,         4'h0, 32'h0);
    go_idle();

    // Randomized transfers against the model.
    for (int n = 0; n < 300; n++) begin
      idx  = $urandom_range(0, 9);
      wr   = 1'($urandom_range(0, 1));
      addr = {$urandom(), 2'b00};
      addr[7:2] = 6'(idx);
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      run_and_check("rand", wr, addr, $urandom(), 4'($urandom_range(0, 15)), $urandom());
      if ($urandom_range(0, 1) == 1) begin
        go_idle();
        check("rand_ctrl", ctrl_o, model[0]);
      end
    end
    go_idle();

    // Reset asserted in the middle of a read access.
    run_and_check("rst_pre", 1, 32'h00, 32'hCAFE_0001, 4'hF, 32'h0);
    go_idle();
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h00;
    @(negedge HCLK);
    PENABLE = 1'b1;
    HRST    = 1'b1;
    #1;
    check("midrst_pready",  {31'd0, PREADY},  32'd0);
    check("midrst_pslverr", {31'd0, PSLVERR}, 32'd0);
    check("midrst_prdata",  PRDATA, 32'd0);
    check("midrst_ctrl",    ctrl_o, 32'd0);
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge HCLK);
    HRST = 1'b0;
    model_reset();
    for (int i = 0; i < NREG; i++) begin
      run_and_check($sformatf("postrst_r%0d", i), 0, 32'(i * 4), 32'h0, 4'h0, 32'h5A5A_0000 + 32'(i));
      go_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
